// File: rtl/watch_mode_ctrl.sv
// Smartwatch UI sequencer: button-driven mode FSM with time/alarm editing, stopwatch control and display mux.
// Optional inactivity timeout in the set modes is enabled by defining WATCH_MODE_AUTO_TIMEOUT_EN.
module watch_mode_ctrl #(
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic [2:0] mode,
  output logic       load_time,
  output logic [4:0] time_hours,
  output logic [5:0] time_minutes,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic       sw_start,
  output logic       sw_reset,
  output logic [4:0] disp_hours,
  output logic [5:0] disp_minutes,
  output logic       blink
);

  typedef enum logic [2:0] {
    ST_CLOCK        = 3'd0,
    ST_SET_HOUR     = 3'd1,
    ST_SET_MIN      = 3'd2,
    ST_SET_ALM_HOUR = 3'd3,
    ST_SET_ALM_MIN  = 3'd4,
    ST_STOPWATCH    = 3'd5
  } state_e;

  if (TIMEOUT_TICKS < 1) begin : g_bad_timeout
    $error("TIMEOUT_TICKS must be at least 1");
  end

  state_e     state_q, state_d;
  logic       mode_prev_q, inc_prev_q;
  logic [4:0] edit_h_q, edit_h_d;
  logic [5:0] edit_m_q, edit_m_d;
  logic       load_time_q, load_time_d;
  logic [4:0] time_h_q, time_h_d;
  logic [5:0] time_m_q, time_m_d;
  logic [4:0] alarm_h_q, alarm_h_d;
  logic [5:0] alarm_m_q, alarm_m_d;
  logic       sw_start_q, sw_start_d;
  logic       sw_reset_q, sw_reset_d;
  logic       blink_q, blink_d;

  logic mode_rise, inc_rise, in_set;

  assign mode_rise = mode_btn & ~mode_prev_q;
  // A simultaneous mode press swallows the inc press.
  assign inc_rise  = inc_btn & ~inc_prev_q & ~mode_rise;
  assign in_set    = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN) ||
                     (state_q == ST_SET_ALM_HOUR) || (state_q == ST_SET_ALM_MIN);

`ifdef WATCH_MODE_AUTO_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    edit_h_d    = edit_h_q;
    edit_m_d    = edit_m_q;
    load_time_d = 1'b0;
    time_h_d    = time_h_q;
    time_m_d    = time_m_q;
    alarm_h_d   = alarm_h_q;
    alarm_m_d   = alarm_m_q;
    sw_start_d  = sw_start_q;
    sw_reset_d  = 1'b0;
    blink_d     = blink_q ^ (tick_1hz & in_set);

    case (state_q)
      ST_CLOCK: begin
        if (mode_rise) begin
          state_d  = ST_SET_HOUR;
          edit_h_d = (cur_hours   > 5'd23) ? 5'd0 : cur_hours;
          edit_m_d = (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
        end
      end
      ST_SET_HOUR: begin
        if (mode_rise)     state_d  = ST_SET_MIN;
        else if (inc_rise) edit_h_d = (edit_h_q == 5'd23) ? 5'd0 : edit_h_q + 5'd1;
      end
      ST_SET_MIN: begin
        if (mode_rise) begin
          state_d     = ST_SET_ALM_HOUR;
          load_time_d = 1'b1;
          time_h_d    = edit_h_q;
          time_m_d    = edit_m_q;
        end else if (inc_rise) begin
          edit_m_d = (edit_m_q == 6'd59) ? 6'd0 : edit_m_q + 6'd1;
        end
      end
      ST_SET_ALM_HOUR: begin
        if (mode_rise)     state_d   = ST_SET_ALM_MIN;
        else if (inc_rise) alarm_h_d = (alarm_h_q == 5'd23) ? 5'd0 : alarm_h_q + 5'd1;
      end
      ST_SET_ALM_MIN: begin
        if (mode_rise)     state_d   = ST_STOPWATCH;
        else if (inc_rise) alarm_m_d = (alarm_m_q == 6'd59) ? 6'd0 : alarm_m_q + 6'd1;
      end
      ST_STOPWATCH: begin
        if (mode_rise) begin
          state_d    = ST_CLOCK;
          sw_reset_d = ~sw_start_q;
        end else if (inc_rise) begin
          sw_start_d = ~sw_start_q;
        end
      end
      default: state_d = ST_CLOCK;
    endcase

`ifdef WATCH_MODE_AUTO_TIMEOUT_EN
    idle_d = idle_q;
    if (!in_set || mode_rise || inc_rise) begin
      idle_d = '0;
    end else if (tick_1hz) begin
      if (idle_q == IDLE_W'(TIMEOUT_TICKS - 1)) begin
        // Abandon the edit: pending time edits are dropped, alarm writes already stuck.
        state_d = ST_CLOCK;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif

    if (state_d != state_q) blink_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CLOCK;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      edit_h_q    <= '0;
      edit_m_q    <= '0;
      load_time_q <= 1'b0;
      time_h_q    <= '0;
      time_m_q    <= '0;
      alarm_h_q   <= '0;
      alarm_m_q   <= '0;
      sw_start_q  <= 1'b0;
      sw_reset_q  <= 1'b0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= mode_btn;
      inc_prev_q  <= inc_btn;
      edit_h_q    <= edit_h_d;
      edit_m_q    <= edit_m_d;
      load_time_q <= load_time_d;
      time_h_q    <= time_h_d;
      time_m_q    <= time_m_d;
      alarm_h_q   <= alarm_h_d;
      alarm_m_q   <= alarm_m_d;
      sw_start_q  <= sw_start_d;
      sw_reset_q  <= sw_reset_d;
      blink_q     <= blink_d;
    end
  end

`ifdef WATCH_MODE_AUTO_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`endif

  always_comb begin
    disp_hours   = cur_hours;
    disp_minutes = cur_minutes;
    case (state_q)
      ST_SET_HOUR, ST_SET_MIN: begin
        disp_hours   = edit_h_q;
        disp_minutes = edit_m_q;
      end
      ST_SET_ALM_HOUR, ST_SET_ALM_MIN: begin
        disp_hours   = alarm_h_q;
        disp_minutes = alarm_m_q;
      end
      default: ;
    endcase
  end

  assign mode          = state_q;
  assign load_time     = load_time_q;
  assign time_hours    = time_h_q;
  assign time_minutes  = time_m_q;
  assign alarm_hours   = alarm_h_q;
  assign alarm_minutes = alarm_m_q;
  assign sw_start      = sw_start_q;
  assign sw_reset      = sw_reset_q;
  assign blink         = blink_q;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Self-checking bench for watch_mode_ctrl: directed test-plan steps, then random presses/ticks
// checked against an event-level model of the mode rules.
module tb_watch_mode_ctrl;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz, mode_btn, inc_btn;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [2:0] mode;
  logic       load_time, sw_start, sw_reset, blink;
  logic [4:0] time_hours, alarm_hours, disp_hours;
  logic [5:0] time_minutes, alarm_minutes, disp_minutes;

  watch_mode_ctrl #(.TIMEOUT_TICKS(T)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .mode(mode), .load_time(load_time),
    .time_hours(time_hours), .time_minutes(time_minutes), .alarm_hours(alarm_hours),
    .alarm_minutes(alarm_minutes), .sw_start(sw_start), .sw_reset(sw_reset),
    .disp_hours(disp_hours), .disp_minutes(disp_minutes), .blink(blink)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: modes numbered 0..5 in press order, a mode press advances cyclically.
  int m_st, m_eh, m_em, m_ah, m_am, m_th, m_tm, m_idle;
  bit m_sw, m_blink, m_load, m_swr, m_pm, m_pi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_eh = 0; m_em = 0; m_ah = 0; m_am = 0; m_th = 0; m_tm = 0; m_idle = 0;
    m_sw = 0; m_blink = 0; m_load = 0; m_swr = 0; m_pm = 0; m_pi = 0;
  endtask

  task automatic model_step(input bit mb, input bit ib, input bit tk);
    bit mr, ir, editing;
    mr = mb && !m_pm;
    ir = ib && !m_pi && !mr;
    m_pm = mb; m_pi = ib;
    m_load = 0; m_swr = 0;
    editing = (m_st >= 1 && m_st <= 4);
    if (mr) begin
      if (m_st == 0) begin
        m_eh = (int'(cur_hours)   < 24) ? int'(cur_hours)   : 0;
        m_em = (int'(cur_minutes) < 60) ? int'(cur_minutes) : 0;
      end else if (m_st == 2) begin
        m_load = 1; m_th = m_eh; m_tm = m_em;
      end else if (m_st == 5) begin
        m_swr = !m_sw;
      end
      m_st = (m_st + 1) % 6;
      m_blink = 0;
      m_idle = 0;
    end else begin
      if (ir) begin
        case (m_st)
          1: m_eh = (m_eh + 1) % 24;
          2: m_em = (m_em + 1) % 60;
          3: m_ah = (m_ah + 1) % 24;
          4: m_am = (m_am + 1) % 60;
          5: m_sw = !m_sw;
          default: ;
        endcase
      end
      if (tk && editing) m_blink = !m_blink;
`ifdef WATCH_MODE_AUTO_TIMEOUT_EN
      if (ir || !editing) m_idle = 0;
      else if (tk) begin
        m_idle++;
        if (m_idle == T) begin
          m_st = 0; m_blink = 0; m_idle = 0;
        end
      end
`endif
    end
  endtask

  task automatic check_all(input string ph);
    int dh, dm;
    dh = int'(cur_hours); dm = int'(cur_minutes);
    if (m_st == 1 || m_st == 2) begin dh = m_eh; dm = m_em; end
    if (m_st == 3 || m_st == 4) begin dh = m_ah; dm = m_am; end
    check({ph, ".mode"},     32'(mode),          32'(m_st));
    check({ph, ".load"},     32'(load_time),     32'(m_load));
    check({ph, ".time_h"},   32'(time_hours),    32'(m_th));
    check({ph, ".time_m"},   32'(time_minutes),  32'(m_tm));
    check({ph, ".alarm_h"},  32'(alarm_hours),   32'(m_ah));
    check({ph, ".alarm_m"},  32'(alarm_minutes), 32'(m_am));
    check({ph, ".sw_start"}, 32'(sw_start),      32'(m_sw));
    check({ph, ".sw_reset"}, 32'(sw_reset),      32'(m_swr));
    check({ph, ".blink"},    32'(blink),         32'(m_blink));
    check({ph, ".disp_h"},   32'(disp_hours),    32'(dh));
    check({ph, ".disp_m"},   32'(disp_minutes),  32'(dm));
  endtask

  // Drive at a falling edge, let one rising edge pass, check at the next falling edge.
  task automatic step(input bit mb, input bit ib, input bit tk, input string ph);
    mode_btn = mb; inc_btn = ib; tick_1hz = tk;
    model_step(mb, ib, tk);
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic press_mode(input string ph);
    step(1, 0, 0, ph);
    step(0, 0, 0, ph);
  endtask

  task automatic press_inc(input int n, input string ph);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, ph);
      step(0, 0, 0, ph);
    end
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 0; mode_btn = 0; inc_btn = 0;
    cur_hours = 5'd10; cur_minutes = 6'd30;
    model_reset();
    #12;
    @(negedge clk);
    check_all("reset");
    reset = 1'b0;
    step(0, 0, 0, "idle");

    // Entry into SET_HOUR snapshots the live time.
    step(1, 0, 0, "enter");
    check("tp1.mode", 32'(mode), 32'd1);
    check("tp1.disp_h", 32'(disp_hours), 32'd10);
    check("tp1.disp_m", 32'(disp_minutes), 32'd30);
    check("tp1.load", 32'(load_time), 32'd0);
    step(0, 0, 0, "enter_rel");

    press_inc(13, "hr_inc");
    check("tp2.edit_h23", 32'(disp_hours), 32'd23);
    press_inc(1, "hr_wrap");
    check("tp2.edit_h0", 32'(disp_hours), 32'd0);
    press_mode("to_min");
    press_inc(29, "min_inc");
    check("tp2.edit_m59", 32'(disp_minutes), 32'd59);
    press_inc(1, "min_wrap");
    check("tp2.edit_m0", 32'(disp_minutes), 32'd0);
    step(1, 0, 0, "commit");
    check("tp2.load", 32'(load_time), 32'd1);
    check("tp2.time_h", 32'(time_hours), 32'd0);
    check("tp2.time_m", 32'(time_minutes), 32'd0);
    check("tp2.mode", 32'(mode), 32'd3);
    step(0, 0, 0, "commit_rel");
    check("tp2.load_once", 32'(load_time), 32'd0);

    press_inc(7, "alm_h");
    press_mode("to_alm_m");
    press_inc(15, "alm_m");
    check("tp3.alarm_h", 32'(alarm_hours), 32'd7);
    check("tp3.alarm_m", 32'(alarm_minutes), 32'd15);
    press_mode("to_sw");

    press_inc(1, "sw_on");
    check("tp4.sw_on", 32'(sw_start), 32'd1);
    press_inc(1, "sw_off");
    check("tp4.sw_off", 32'(sw_start), 32'd0);
    step(1, 0, 0, "sw_exit");
    check("tp4.sw_reset", 32'(sw_reset), 32'd1);
    check("tp4.mode", 32'(mode), 32'd0);
    step(0, 0, 0, "sw_exit_rel");
    check("tp4.sw_reset_once", 32'(sw_reset), 32'd0);
    check("tp3.alarm_keep", 32'(alarm_hours * 100 + alarm_minutes), 32'd715);

    press_mode("re_enter");
    step(1, 1, 0, "both");
    check("tp5.mode", 32'(mode), 32'd2);
    check("tp5.edit_h", 32'(disp_hours), 32'd10);
    step(0, 0, 0, "both_rel");
    for (int i = 0; i < 100; i++) step(0, 1, 0, "held");
    step(0, 0, 0, "held_rel");
    check("tp5.held_once", 32'(disp_minutes), 32'd31);

    // Inactivity in SET_MIN: ticks only.
    for (int i = 0; i < T - 1; i++) step(0, 0, 1, "idle_tick");
    check("tp6.before_limit", 32'(mode), 32'd2);
    step(0, 0, 1, "idle_limit");
`ifdef WATCH_MODE_AUTO_TIMEOUT_EN
    check("tp6.timeout_mode", 32'(mode), 32'd0);
`else
    check("tp6.persist_mode", 32'(mode), 32'd2);
`endif
    check("tp6.no_load", 32'(load_time), 32'd0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, "idle_more");

    // Reset mid-edit with a non-zero alarm.
    cur_hours = 5'd4; cur_minutes = 6'd5;
    while (m_st != 3) press_mode("seek_alm");
    press_inc(3, "alm_pre");
    while (m_st != 2) press_mode("seek_min");
    press_inc(2, "min_pre");
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    check_all("rst_held");
    check("tp7.alarm_h", 32'(alarm_hours), 32'd0);
    reset = 1'b0;
    step(0, 0, 0, "post_rst");

    // Random presses, ticks and live values (including out-of-range).
    for (int i = 0; i < 800; i++) begin
      cur_hours   = 5'($urandom_range(0, 31));
      cur_minutes = 6'($urandom_range(0, 63));
      step($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
